shift_left_saturate_stream: RTL and testbench

- Streaming fixed-point up-scaler: the widening counterpart of the team's shift-right-with-round narrowing operators.
- Takes IN_WIDTH samples, applies a per-sample left shift of 0..2^SHIFT_WIDTH-1 and saturates the result to OUT_WIDTH.
- Supports signed or unsigned interpretation.
- Two-stage valid/ready pipeline with a saturation event counter; sits between quantized datapath stages and wider accumulators/DAC paths.

---
 rtl/shift_left_saturate_stream_if.sv | 27 ++
 rtl/shift_left_saturate_stream.sv | 91 +++++++++
 tb/tb_shift_left_saturate_stream.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_left_saturate_stream_if.sv
// Stream bundle for the left-shift/saturate up-scaler: input sample side and
// output sample side, both valid/ready.
interface shift_left_saturate_stream_if #(
  parameter int IN_WIDTH    = 10,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_WIDTH-1:0]    din;
  logic [SHIFT_WIDTH-1:0] shift_amt;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   dout;
  logic                   sat_flag;

  modport master (
    output in_valid, din, shift_amt, signed_mode, out_ready,
    input  in_ready, out_valid, dout, sat_flag
  );

  modport slave (
    input  in_valid, din, shift_amt, signed_mode, out_ready,
    output in_ready, out_valid, dout, sat_flag
  );
endinterface

// File: rtl/shift_left_saturate_stream.sv
// Streaming up-scaler: per-sample left shift, saturate to OUT_WIDTH (signed or
// unsigned), two-stage valid/ready pipeline plus a sticky saturation counter.
module shift_left_saturate_stream #(
  parameter int IN_WIDTH    = 10,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_left_saturate_stream_if.slave bus,
  input  logic                 sat_clr,
  output logic [CNT_WIDTH-1:0] sat_count
);
  // Wide enough that no shift can lose bits before saturation is judged.
  localparam int W = IN_WIDTH + 2**SHIFT_WIDTH - 1;

  typedef struct packed {
    logic         sgn;
    logic [W-1:0] wide;
  } s1_t;

  typedef struct packed {
    logic                 sat;
    logic [OUT_WIDTH-1:0] data;
  } s2_t;

  logic [2:1]           vld_pipe;
  s1_t                  s1_q;
  s2_t                  s2_q, s2_d;
  logic                 s1_adv, s2_adv, sat_xfer;
  logic [W-1:0]         ext;
  logic [W-OUT_WIDTH:0] hi_s;
  logic [W-OUT_WIDTH-1:0] hi_u;

  assign s2_adv       = ~vld_pipe[2] | bus.out_ready;
  assign s1_adv       = ~vld_pipe[1] | s2_adv;
  assign bus.in_ready = s1_adv;

  assign ext = {{(W-IN_WIDTH){bus.signed_mode & bus.din[IN_WIDTH-1]}}, bus.din};

  assign hi_s = s1_q.wide[W-1:OUT_WIDTH-1];
  assign hi_u = s1_q.wide[W-1:OUT_WIDTH];

  always_comb begin
    s2_d.sat  = 1'b0;
    s2_d.data = s1_q.wide[OUT_WIDTH-1:0];
    if (s1_q.sgn) begin
      // Bits above the output sign must all match it, else clip toward the sign.
      if (!(&hi_s) && (|hi_s)) begin
        s2_d.sat  = 1'b1;
        s2_d.data = {s1_q.wide[W-1], {(OUT_WIDTH-1){~s1_q.wide[W-1]}}};
      end
    end else if (|hi_u) begin
      s2_d.sat  = 1'b1;
      s2_d.data = '1;
    end
  end

  // Stage-1 payload needs no reset: it is only consumed behind vld_pipe[1].
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      s1_q.sgn  <= bus.signed_mode;
      s1_q.wide <= ext << bus.shift_amt;
    end
  end

  assign sat_xfer = vld_pipe[2] & bus.out_ready & s2_q.sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s2_q      <= '0;
      sat_count <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= bus.in_valid;
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
      if (sat_clr)
        sat_count <= CNT_WIDTH'(sat_xfer);
      else if (sat_xfer && !(&sat_count))
        sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.dout      = s2_q.data;
  assign bus.sat_flag  = s2_q.sat;
endmodule

// File: tb/tb_shift_left_saturate_stream.sv
// Scoreboard bench for shift_left_saturate_stream: directed corner cases plus
// randomized traffic with random backpressure and sat_clr.
module tb_shift_left_saturate_stream;
  localparam int IW = 10, OW = 16, SW = 4, CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sat_clr = 1'b0;
  logic [CW-1:0] sat_count;
  int            checks = 0, errors = 0;
  int            n_in = 0, n_out = 0;
  logic [OW:0]   exp_q[$];
  logic [CW-1:0] cnt_m = '0;
  logic          hold_v = 1'b0;
  logic [OW:0]   hold_d;
  logic          rnd_on;

  always #5 clk = ~clk;

  shift_left_saturate_stream_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)) bus ();

  shift_left_saturate_stream #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: integer value times 2^shift, then clip to the output range.
  function automatic logic [OW:0] model(input logic [IW-1:0] d, input logic [SW-1:0] sh,
                                        input logic sm);
    longint v, r, smax, smin, umax;
    logic [OW:0] res;
    smax = (longint'(1) << (OW-1)) - 1;
    smin = -(longint'(1) << (OW-1));
    umax = (longint'(1) << OW) - 1;
    v = longint'(d);
    if (sm && d[IW-1]) v = v - (longint'(1) << IW);
    r = v * (longint'(1) << sh);
    if (sm) begin
      if (r > smax)      res = {1'b1, r[OW-1:0] & 16'h0 | smax[OW-1:0]};
      else if (r < smin) res = {1'b1, smin[OW-1:0]};
      else               res = {1'b0, r[OW-1:0]};
    end else begin
      if (r > umax) res = {1'b1, umax[OW-1:0]};
      else          res = {1'b0, r[OW-1:0]};
    end
    return res;
  endfunction

  // Input monitor: push expectation for every accepted sample.
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.din, bus.shift_amt, bus.signed_mode));
      n_in++;
    end
  end

  // Output monitor: compare transfers, stall stability and the counter.
  always @(negedge clk) begin
    logic [OW:0] e;
    logic        xs;
    chk("sat_count", 32'(sat_count), 32'(cnt_m));
    if (rst) begin
      exp_q.delete();
      cnt_m  = '0;
      hold_v = 1'b0;
    end else begin
      xs = 1'b0;
      if (hold_v) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'({bus.sat_flag, bus.dout}), 32'(hold_d));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          xs = e[OW];
          chk("dout", 32'(bus.dout), 32'(e[OW-1:0]));
          chk("sat_flag", 32'(bus.sat_flag), 32'(e[OW]));
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = {bus.sat_flag, bus.dout};
      if (sat_clr)              cnt_m = xs ? CW'(1) : '0;
      else if (xs && !(&cnt_m)) cnt_m = cnt_m + CW'(1);
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic [SW-1:0] sh, input logic sm);
    int n = 0;
    bus.in_valid = 1'b1; bus.din = d; bus.shift_amt = sh; bus.signed_mode = sm;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 200);
    if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din = IW'($urandom); bus.shift_amt = SW'($urandom); bus.signed_mode = 1'($urandom);
  endtask

  task automatic expect_one(input string nm, input logic [IW-1:0] d, input logic [SW-1:0] sh,
                            input logic sm, input logic [OW-1:0] ed, input logic ef);
    send(d, sh, sm);
    @(negedge clk);
    chk({nm, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_dout"}, 32'(bus.dout), 32'(ed));
    chk({nm, "_flag"}, 32'(bus.sat_flag), 32'(ef));
    @(posedge clk); #1;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_in, b_out, cyc;
    bus.in_valid = 1'b0; bus.din = '0; bus.shift_amt = '0; bus.signed_mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_sat_flag", 32'(bus.sat_flag), 32'd0);
    @(posedge clk); #1;

    expect_one("s1ff_sh6", 10'h1FF, 4'd6, 1'b1, 16'h7FC0, 1'b0);
    expect_one("s1ff_sh7", 10'h1FF, 4'd7, 1'b1, 16'h7FFF, 1'b1);
    expect_one("s1ff_sh15", 10'h1FF, 4'd15, 1'b1, 16'h7FFF, 1'b1);
    expect_one("s200_sh6", 10'h200, 4'd6, 1'b1, 16'h8000, 1'b0);
    expect_one("s200_sh7", 10'h200, 4'd7, 1'b1, 16'h8000, 1'b1);
    expect_one("s3ff_sh0", 10'h3FF, 4'd0, 1'b1, 16'hFFFF, 1'b0);
    clr_pulse();
    @(negedge clk) chk("clr_alone", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    expect_one("u3ff_sh6", 10'h3FF, 4'd6, 1'b0, 16'hFFC0, 1'b0);
    expect_one("u3ff_sh7", 10'h3FF, 4'd7, 1'b0, 16'hFFFF, 1'b1);
    @(negedge clk) chk("count_one", 32'(sat_count), 32'd1);
    @(posedge clk); #1;

    // Backpressure: 4 stalled cycles, only two samples fit.
    bus.out_ready = 1'b0;
    b_in = n_in; b_out = n_out;
    fork
      for (int i = 0; i < 5; i++) send(IW'(i * 97 + 5), SW'(i), i[0]);
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("bp_accepted", 32'(n_in - b_in), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        cyc = 0;
        while (n_out - b_out < 5 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        chk("bp_outputs", 32'(n_out - b_out), 32'd5);
        chk("bp_cycles", 32'(cyc), 32'd5);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Counter sticks at all-ones, then clear interactions.
    for (int i = 0; i < 18; i++) send(10'h1FF, 4'd15, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk) chk("count_stick", 32'(sat_count), 32'(2**CW - 1));
    @(posedge clk); #1;
    send(10'h1FF, 4'd15, 1'b1);
    @(posedge clk); #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    @(negedge clk) chk("clr_with_sat", 32'(sat_count), 32'd1);
    clr_pulse();
    @(negedge clk) chk("clr_alone2", 32'(sat_count), 32'd0);
    @(posedge clk); #1;

    // Reset with two samples in flight.
    bus.out_ready = 1'b0;
    send(10'h155, 4'd9, 1'b0);
    send(10'h0AA, 4'd3, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flight_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_flight_count", 32'(sat_count), 32'd0);
    bus.out_ready = 1'b1;
    b_out = n_out;
    repeat (5) @(negedge clk);
    #1 chk("rst_no_stale", 32'(n_out - b_out), 32'd0);
    @(posedge clk); #1;

    // Random traffic with random backpressure and clears.
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [IW-1:0] d;
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          case ($urandom_range(0, 3))
            0:       d = 10'h1FF;
            1:       d = 10'h200;
            default: d = IW'($urandom);
          endcase
          send(d, SW'($urandom), 1'($urandom));
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        sat_clr = ($urandom_range(0, 15) == 0);
      end
    join
    @(posedge clk); #1;
    bus.out_ready = 1'b1; sat_clr = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
